// File: rtl/axis_output_serializer_pkg.sv
// axis_output_serializer_pkg: default geometry and helpers for the output serializer
package axis_output_serializer_pkg;
  localparam int WORD_WIDTH_ACC_DEF = 32;
  localparam int S_WORDS_DEF = 16;
  localparam int M_WORDS_DEF = 4;
  localparam int TUSER_WIDTH_DEF = 8;
  localparam int I_IS_CONFIG_DEF = 0;
  function automatic bit is_pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/axis_output_serializer.sv
// axis_output_serializer: splits wide result beats into BEATS narrow AXI-stream words
// Define OUT_DROP_CONFIG_EN to swallow beats flagged by s_axis_tuser[I_IS_CONFIG].
module axis_output_serializer
  import axis_output_serializer_pkg::*;
#(
  parameter int WORD_WIDTH_ACC = WORD_WIDTH_ACC_DEF,
  parameter int S_WORDS = S_WORDS_DEF,
  parameter int M_WORDS = M_WORDS_DEF,
  parameter int TUSER_WIDTH = TUSER_WIDTH_DEF,
  parameter int I_IS_CONFIG = I_IS_CONFIG_DEF
) (
  input  logic aclk,
  input  logic aresetn,
  output logic s_axis_tready,
  input  logic s_axis_tvalid,
  input  logic s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [WORD_WIDTH_ACC*S_WORDS-1:0] s_axis_tdata,
  input  logic m_axis_tready,
  output logic m_axis_tvalid,
  output logic m_axis_tlast,
  output logic [WORD_WIDTH_ACC*M_WORDS-1:0] m_axis_tdata,
  output logic [WORD_WIDTH_ACC*M_WORDS/8-1:0] m_axis_tkeep
);
  localparam int BEATS = S_WORDS / M_WORDS;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int SW = WORD_WIDTH_ACC * M_WORDS;
  if (!is_pow2(BEATS) || BEATS < 2 || S_WORDS % M_WORDS != 0) begin : g_bad_geometry
    $error("axis_output_serializer: S_WORDS/M_WORDS must be a power of 2 >= 2");
  end
  logic full, last_r, last_slice, load;
  logic [CW-1:0] cnt;
  logic [WORD_WIDTH_ACC*S_WORDS-1:0] buf_q;
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;
  assign last_slice = cnt == CW'(BEATS - 1);
  assign s_axis_tready = aresetn && (!full || (m_axis_tready && last_slice));
`ifdef OUT_DROP_CONFIG_EN
  assign load = s_axis_tvalid && s_axis_tready && !s_axis_tuser[I_IS_CONFIG];
`else
  assign load = s_axis_tvalid && s_axis_tready;
`endif
  assign m_axis_tvalid = full;
  assign m_axis_tlast = last_r && last_slice;
  assign m_axis_tdata = buf_q[int'(cnt) * SW +: SW];
  assign m_axis_tkeep = '1;
  // a load on the final slice overrides the drain, giving bubble-free back-to-back beats
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      full <= 1'b0;
      last_r <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      buf_q <= s_axis_tdata;
      last_r <= s_axis_tlast;
      cnt <= '0;
      full <= 1'b1;
    end else if (full && m_axis_tready) begin
      cnt <= last_slice ? '0 : cnt + 1'b1;
      full <= !last_slice;
    end
  end
endmodule

// File: tb/tb_axis_output_serializer.sv
// tb_axis_output_serializer: directed vectors for the 16-to-4 word serializer
module tb_axis_output_serializer;
  logic clk = 0, aresetn = 0;
  logic s_ready, s_valid = 0, s_last = 0, m_ready = 1, m_valid, m_last;
  logic [7:0] s_user = 0;
  logic [511:0] s_data = 0;
  logic [127:0] m_data;
  logic [15:0] m_keep;
  int vecs = 0, errs = 0, cyc = 0, vcnt = 0, first_v = -1, last_v = -1;
  logic [127:0] od[$];
  logic ol[$];
  always #5 clk = ~clk;
  axis_output_serializer dut (
    .aclk(clk), .aresetn(aresetn), .s_axis_tready(s_ready), .s_axis_tvalid(s_valid),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user), .s_axis_tdata(s_data),
    .m_axis_tready(m_ready), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep)
  );
  always @(negedge clk) begin
    cyc++;
    if (aresetn && m_valid) begin
      vcnt++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      if (m_ready) begin
        od.push_back(m_data);
        ol.push_back(m_last);
      end
    end
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [511:0] mk_beat(input int base);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = 32'(base + i);
    return d;
  endfunction
  function automatic logic [127:0] slice(input int base, input int k);
    logic [127:0] e;
    for (int j = 0; j < 4; j++) e[32*j +: 32] = 32'(base + 4*k + j);
    return e;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_mon();
    od.delete();
    ol.delete();
    vcnt = 0;
    first_v = -1;
    last_v = -1;
  endtask
  task automatic send(input int base, input bit last, input bit user);
    int n = 0;
    s_valid = 1;
    s_data = mk_beat(base);
    s_last = last;
    s_user = {7'b0, user};
    #1;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (!s_ready) check("send_timeout", 0, 1);
    step();
    s_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (m_valid && n < 100) begin
      step();
      n++;
    end
    if (m_valid) check("drain_timeout", 0, 1);
  endtask
  initial begin
    repeat (2) step();
    check("rst_valid", m_valid, 0);
    check("rst_ready", s_ready, 0);
    check("rst_last", m_last, 0);
    check("tkeep", m_keep, 16'hFFFF);
    aresetn = 1;
    #1;
    check("empty_ready", s_ready, 1);
    // single beat, per-cycle view
    send(0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", m_valid, 1);
      check("t1_data", m_data, slice(0, k));
      check("t1_last", m_last, k == 3);
      check("t1_sready", s_ready, k == 3);
      step();
    end
    check("t1_done_valid", m_valid, 0);
    check("t1_done_ready", s_ready, 1);
    // three back-to-back beats
    clear_mon();
    send(100, 0, 0);
    send(200, 0, 0);
    send(300, 1, 0);
    drain();
    check("t2_count", od.size(), 12);
    check("t2_span", last_v - first_v + 1, 12);
    check("t2_vcycles", vcnt, 12);
    for (int i = 0; i < 12 && i < od.size(); i++) begin
      check("t2_data", od[i], slice(100 * (i / 4 + 1), i % 4));
      check("t2_last", ol[i], i == 11);
    end
    // output stalls
    clear_mon();
    send(500, 1, 0);
    for (int i = 0; i < 7; i++) begin
      logic [127:0] prev;
      m_ready = (i % 2 == 0);
      #1;
      prev = m_data;
      step();
      if (i % 2 == 1) begin
        check("t3_hold_data", m_data, prev);
        check("t3_hold_valid", m_valid, 1);
      end
    end
    m_ready = 1;
    check("t3_done", m_valid, 0);
    check("t3_count", od.size(), 4);
    for (int i = 0; i < 4 && i < od.size(); i++) check("t3_data", od[i], slice(500, i));
    // config beat then data beat
    clear_mon();
    send(600, 0, 1);
    send(700, 1, 0);
    drain();
`ifdef OUT_DROP_CONFIG_EN
    check("t4_count", od.size(), 4);
    if (od.size() == 4) begin
      check("t4_first", od[0], slice(700, 0));
      check("t4_last", ol[3], 1);
    end
`else
    check("t4_count", od.size(), 8);
    if (od.size() == 8) begin
      check("t4_cfg", od[0], slice(600, 0));
      check("t4_cfg_last", ol[3], 0);
      check("t4_data", od[4], slice(700, 0));
      check("t4_last", ol[7], 1);
    end
`endif
    // reset mid-beat
    clear_mon();
    send(800, 1, 0);
    step();
    step();
    aresetn = 0;
    step();
    aresetn = 1;
    #1;
    check("t5_valid", m_valid, 0);
    check("t5_ready", s_ready, 1);
    check("t5_last", m_last, 0);
    send(900, 1, 0);
    drain();
    check("t5_count", od.size(), 6);
    if (od.size() == 6) begin
      check("t5_pre_last", ol[1], 0);
      check("t5_restart", od[2], slice(900, 0));
      check("t5_end", ol[5], 1);
    end
    // input gaps
    send(1000, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("t6_busy", m_valid, 1);
      step();
    end
    for (int g = 0; g < 3; g++) begin
      check("t6_gap_valid", m_valid, 0);
      check("t6_gap_ready", s_ready, 1);
      step();
    end
    send(1100, 1, 0);
    check("t6_resume", m_data, slice(1100, 0));
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
